// File: rtl/read_ptr_ctrl.sv
// read_ptr_ctrl: async-FIFO read-domain pointer, empty flag and underflow status.
// Define RD_LEVEL_EN to build the fill-level / almost-empty path.
module read_ptr_ctrl #(
    parameter int ADDRSIZE  = 9,
    parameter int AE_THRESH = 4
) (
    input  logic                rclk,
    input  logic                r_rst,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wptr_sync,
    input  logic                uflow_clr,
    output logic [ADDRSIZE:0]   raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                ralmost_empty,
    output logic                runderflow
);
    logic [ADDRSIZE:0] raddr_q, raddr_d, rptr_q, rptr_d;
    logic              rempty_q, rempty_d, uflow_q, uflow_d, ae_q, ae_d;
    logic              accept;

    always_comb begin
        accept   = rinc & ~rempty_q;
        raddr_d  = raddr_q + {{ADDRSIZE{1'b0}}, accept};
        rptr_d   = (raddr_d >> 1) ^ raddr_d;
        rempty_d = rptr_d == wptr_sync;
        // a same-cycle underflow beats the clear
        uflow_d  = (rinc & rempty_q) | (uflow_q & ~uflow_clr);
    end

    always_ff @(posedge rclk or posedge r_rst) begin
        if (r_rst) begin
            raddr_q  <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
            uflow_q  <= 1'b0;
            ae_q     <= 1'b1;
        end else begin
            raddr_q  <= raddr_d;
            rptr_q   <= rptr_d;
            rempty_q <= rempty_d;
            uflow_q  <= uflow_d;
            ae_q     <= ae_d;
        end
    end

`ifdef RD_LEVEL_EN
    localparam logic [ADDRSIZE:0] AE = (ADDRSIZE+1)'(AE_THRESH);
    logic [ADDRSIZE:0] wbin, level_d, rlevel_q;

    always_comb begin
        for (int i = 0; i <= ADDRSIZE; i++) wbin[i] = ^(wptr_sync >> i);
        level_d = wbin - raddr_d;
        ae_d    = level_d <= AE;
    end

    always_ff @(posedge rclk or posedge r_rst) begin
        if (r_rst) rlevel_q <= '0;
        else       rlevel_q <= level_d;
    end

    assign rlevel = rlevel_q;
`else
    assign ae_d   = rempty_d;
    assign rlevel = '0;
`endif

    assign raddr         = raddr_q;
    assign rptr          = rptr_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ae_q;
    assign runderflow    = uflow_q;

    a_reset_vals: assert property (@(posedge rclk)
        r_rst |-> (raddr_q == '0 && rptr_q == '0 && rempty_q));
    a_empty_hold: assert property (@(posedge rclk) disable iff (r_rst)
        (rempty_q && rinc) |-> raddr_d == raddr_q);
    a_gray_step: assert property (@(posedge rclk) disable iff (r_rst)
        $onehot0(rptr_d ^ rptr_q));
endmodule

// File: tb/tb_read_ptr_ctrl.sv
// tb_read_ptr_ctrl: directed self-checking bench for read_ptr_ctrl (either RD_LEVEL_EN build).
module tb_read_ptr_ctrl;
    localparam int AW = 9;
    logic rclk = 1'b0, r_rst = 1'b0, rinc = 1'b0, uflow_clr = 1'b0;
    logic [AW:0] wptr_sync = '0;
    logic [AW:0] raddr, rptr, rlevel;
    logic rempty, ralmost_empty, runderflow;
    logic [32:0] obs, exp_v;
    int tests = 0, fails = 0;

    assign obs = {raddr, rptr, rempty, rlevel, ralmost_empty, runderflow};

    read_ptr_ctrl #(.ADDRSIZE(AW), .AE_THRESH(4)) dut (
        .rclk(rclk), .r_rst(r_rst), .rinc(rinc), .wptr_sync(wptr_sync),
        .uflow_clr(uflow_clr), .raddr(raddr), .rptr(rptr), .rempty(rempty),
        .rlevel(rlevel), .ralmost_empty(ralmost_empty), .runderflow(runderflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // {raddr, rptr, rempty, rlevel, ralmost_empty, runderflow}
    function automatic logic [32:0] expect_state(input logic [AW:0] a, input logic e,
                                                 input logic [AW:0] lv, input logic u);
`ifdef RD_LEVEL_EN
        return {a, gray(a), e, lv, lv <= 10'd4, u};
`else
        return {a, gray(a), e, {(AW+1){1'b0}}, e, u};
`endif
    endfunction

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        exp_v = expect_state(10'd0, 1'b1, 10'd0, 1'b0);
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL reset_init: got %h want %h", obs, exp_v); end
        wptr_sync = gray(10'd40);
        tick();
        rinc = 1'b1;
        repeat (37) tick();
        rinc = 1'b0;
        exp_v = expect_state(10'd37, 1'b0, 10'd3, 1'b0);
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL reset_pre37: got %h want %h", obs, exp_v); end
        r_rst = 1'b1;
        #1;
        exp_v = expect_state(10'd0, 1'b1, 10'd0, 1'b0);
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL reset_async: got %h want %h", obs, exp_v); end
        tick();
        r_rst = 1'b0;
    endtask

    task automatic test_basic_drain();
        logic [AW:0] rp_tab [3];
        rp_tab = '{10'd1, 10'd3, 10'd2};
        wptr_sync = 10'd2;
        tick();
        exp_v = expect_state(10'd0, 1'b0, 10'd3, 1'b0);
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL drain_visible: got %h want %h", obs, exp_v); end
        rinc = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_v = expect_state(10'(i), i == 3, 10'(3 - i), 1'b0);
            tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL drain_rd%0d: got %h want %h", i, obs, exp_v); end
            tests++;
            if (rptr !== rp_tab[i-1]) begin fails++; $display("FAIL drain_rptr%0d: got %0d want %0d", i, rptr, rp_tab[i-1]); end
        end
        rinc = 1'b0;
    endtask

    task automatic test_underflow();
        rinc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = expect_state(10'd3, 1'b1, 10'd0, 1'b1);
            tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL uflow_set%0d: got %h want %h", i, obs, exp_v); end
        end
        rinc = 1'b0;
        uflow_clr = 1'b1;
        tick();
        exp_v = expect_state(10'd3, 1'b1, 10'd0, 1'b0);
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL uflow_clr: got %h want %h", obs, exp_v); end
        rinc = 1'b1;
        tick();
        exp_v = expect_state(10'd3, 1'b1, 10'd0, 1'b1);
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL uflow_set_wins: got %h want %h", obs, exp_v); end
        rinc = 1'b0;
        uflow_clr = 1'b0;
        tick();
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL uflow_sticky: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_wrap();
        do_reset();
        wptr_sync = gray(10'd512);
        tick();
        rinc = 1'b1;
        repeat (512) tick();
        rinc = 1'b0;
        exp_v = expect_state(10'd512, 1'b1, 10'd0, 1'b0);
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL wrap_half: got %h want %h", obs, exp_v); end
        wptr_sync = 10'd0;
        tick();
        exp_v = expect_state(10'd512, 1'b0, 10'd512, 1'b0);
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL wrap_full: got %h want %h", obs, exp_v); end
        rinc = 1'b1;
        repeat (511) tick();
        rinc = 1'b0;
        exp_v = expect_state(10'd1023, 1'b0, 10'd1, 1'b0);
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL wrap_1023: got %h want %h", obs, exp_v); end
        tests++;
        if (rptr !== 10'd512) begin fails++; $display("FAIL wrap_rptr: got %0d want 512", rptr); end
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        exp_v = expect_state(10'd0, 1'b1, 10'd0, 1'b0);
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL wrap_zero: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_almost_empty();
        do_reset();
        wptr_sync = 10'd7;
        tick();
        exp_v = expect_state(10'd0, 1'b0, 10'd5, 1'b0);
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL ae_level5: got %h want %h", obs, exp_v); end
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        exp_v = expect_state(10'd1, 1'b0, 10'd4, 1'b0);
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL ae_level4: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_back_to_back();
        wptr_sync = gray(10'd6);
        rinc = 1'b1;
        tick();
        exp_v = expect_state(10'd2, 1'b0, 10'd4, 1'b0);
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL b2b_wr_rd: got %h want %h", obs, exp_v); end
        for (int i = 3; i <= 6; i++) begin
            tick();
            exp_v = expect_state(10'(i), i == 6, 10'(6 - i), 1'b0);
            tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL b2b_rd%0d: got %h want %h", i, obs, exp_v); end
        end
        rinc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_underflow();
        test_wrap();
        test_almost_empty();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/read_ptr_ctrl.md
Name: read_ptr_ctrl

Overview:
Read-domain pointer and status controller for the asynchronous FIFO. It is the counterpart of the write-side pointer logic.
- Advances the binary read address on accepted reads and publishes a Gray-coded read pointer for synchronization into the write domain.
- Derives a registered empty flag from the write pointer, which is already synchronized into rclk.
- Adds fill level, almost-empty and sticky underflow status for the read-side consumer.

Parameters:
ADDRSIZE, 9, memory address width; FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
AE_THRESH, 4, almost-empty threshold in entries (0 .. 2**ADDRSIZE).

Ports:
rclk  input  1  read-domain clock.
r_rst  input  1  asynchronous, active-high reset.
rinc  input  1  read request; accepted only when rempty=0.
wptr_sync  input  ADDRSIZE+1  write Gray pointer, already synchronized to rclk.
uflow_clr  input  1  synchronous clear of runderflow.
raddr  output  ADDRSIZE+1  binary read counter; memory uses raddr[ADDRSIZE-1:0].
rptr  output  ADDRSIZE+1  Gray read pointer, to the write-domain synchronizer.
rempty  output  1  FIFO empty, registered.
rlevel  output  ADDRSIZE+1  entries available to read, registered.
ralmost_empty  output  1  rlevel <= AE_THRESH, registered.
runderflow  output  1  sticky: read attempted while empty.

Behaviour:
- Clocking and reset
  - All state updates on posedge rclk; r_rst is asynchronous and active-high.
  - Reset values: raddr=0, rptr=0, rempty=1, rlevel=0, ralmost_empty=1, runderflow=0.
  - Reset asserted mid-operation forces these values immediately, independent of rclk.
- Accept and pointer update
  - accept = rinc & ~rempty.
  - raddr_next = raddr + accept, modulo 2**(ADDRSIZE+1); it wraps from all-ones to 0.
  - rptr_next = (raddr_next>>1) ^ raddr_next.
  - raddr and rptr both register their _next values every cycle.
- Empty flag
  - rempty <= (rptr_next == wptr_sync).
  - The flag updates in the same cycle as the pointer, so the read that drains the last entry raises rempty on that edge.
- Fill level
  - wbin = Gray-to-binary of wptr_sync: bit i = XOR of wptr_sync[ADDRSIZE:i].
  - rlevel <= wbin - raddr_next, modulo 2**(ADDRSIZE+1). Valid range is 0 .. 2**ADDRSIZE.
  - ralmost_empty <= (wbin - raddr_next) <= AE_THRESH.
- Underflow
  - rinc & rempty leaves raddr/rptr unchanged and sets runderflow on the next edge.
  - runderflow holds until uflow_clr=1 at a clock edge (clears to 0) or r_rst.
  - If uflow_clr and an underflowing read occur in the same cycle, set wins: runderflow=1.
- Timing and write-side interaction
  - Latency: one rclk from rinc to raddr/rptr/flag update. A write becomes visible only once wptr_sync changes, then one rclk later.
  - A simultaneous wptr_sync change and accepted read both take effect in the same computation.
- Assertions (outside the optional feature)
  - After r_rst: raddr==0 && rptr==0 && rempty==1.
  - rempty implies raddr does not change on rinc.
  - rptr changes by at most one bit per cycle.

Optional Feature:
Macro RD_LEVEL_EN.
- Defined: rlevel and ralmost_empty are produced as specified above.
- Undefined:
  - The Gray-to-binary converter and subtractor are not built.
  - rlevel is tied to 0.
  - ralmost_empty equals rempty.
  - Pointer, rempty and runderflow behaviour are identical in both builds.

Test Plan:
- Reset: assert r_rst mid-stream with raddr=37 -> immediately raddr=0, rptr=0, rempty=1, rlevel=0, ralmost_empty=1, runderflow=0.
- Basic drain: wptr_sync=2 (gray of 3), rinc=0 for 1 clk -> rempty=0, rlevel=3.
  - Then rinc=1 for 3 clks -> raddr 1,2,3; rptr 1,3,2; rlevel 2,1,0; rempty=1 after the 3rd edge.
- Underflow: rempty=1, rinc=1 for 2 clks -> raddr held, runderflow=1 and remains 1.
  - uflow_clr=1 for 1 clk -> runderflow=0.
  - Same-cycle clr plus underflowing read -> runderflow stays 1.
- Wrap-around: raddr=1023 (rptr=512), wptr_sync=0 -> rlevel=1, rempty=0.
  - rinc=1 -> raddr=0, rptr=0, rempty=1, rlevel=0.
- Almost-empty: AE_THRESH=4, wptr_sync=7 (gray of 5), raddr=0 -> rlevel=5, ralmost_empty=0.
  - One read -> rlevel=4, ralmost_empty=1.
- Build without RD_LEVEL_EN: repeat the basic drain -> identical raddr/rptr/rempty, rlevel=0 throughout, ralmost_empty tracks rempty.
